fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch and program-sequencing unit for the lab processor.
- Owns the program counter and produces the fetch address for instruction memory each cycle.
- Consumes the ALU `branch` flag and a decoded halt/branch-index field, and applies PC-relative branches through a small offset lookup table.
- Provides the start/done handshake with the testbench/top level and counts executed instructions.

Parameters:
- PC_W, 10, program counter width; PC wraps modulo 2^PC_W.
- OFF_W, 8, width of signed branch offsets held in the lookup table.
- IDX_W, 5, branch-index width; the table has 2^IDX_W entries.
- CNT_W, 16, width of the executed-instruction counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- START  input  1  request to begin execution; honoured in IDLE and HALTED only.
- START_ADDR  input  PC_W  PC loaded when START is accepted.
- BRANCH  input  1  ALU branch-taken flag for the current instruction.
- BR_IDX  input  IDX_W  branch-offset table index, from the instruction field.
- HALT  input  1  decoded halt instruction.
- STALL  input  1  freeze sequencing this cycle.
- PC  output  PC_W  current fetch address.
- INST_VALID  output  1  high while in RUN; the current PC holds a live instruction.
- DONE  output  1  registered; high while in HALTED.
- INST_CNT  output  CNT_W  executed (non-stalled RUN) cycles since last START.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high.
- Reset values: state IDLE, PC=0, DONE=0, INST_CNT=0, INST_VALID=0.
- A Reset asserted mid-run returns the block to these values at the next edge, regardless of all other inputs.
- Encoding: states IDLE, RUN, HALTED. INST_VALID = (state==RUN), decoded combinationally from state.
- IDLE:
  - START=1 → PC<=START_ADDR, INST_CNT<=0, DONE<=0, go to RUN.
  - Otherwise everything holds.
- RUN, per edge, with priority STALL > HALT > BRANCH > sequential:
  - STALL=1: PC, INST_CNT and state hold. A HALT or BRANCH in the same cycle is ignored.
  - HALT=1: go to HALTED, DONE<=1, PC holds, INST_CNT+1.
  - BRANCH=1: PC <= PC + sext(BR_LUT[BR_IDX]), truncated to PC_W, INST_CNT+1.
  - Else: PC <= PC+1 (wraps 0x3FF→0x000 at default width), INST_CNT+1.
- START is ignored while in RUN.
- INST_CNT saturates at all-ones; it never wraps.
- HALTED:
  - DONE=1, PC and INST_CNT frozen.
  - START=1 → behaves exactly as in IDLE: reload PC, clear INST_CNT, DONE<=0 on the same edge, go to RUN.
- Latency: a BRANCH/HALT sampled at edge N takes effect on PC/DONE visible after edge N. No delay slot.

Decomposition:
- Add to package `definitions`:
  - fetch_state enum {IDLE, RUN, HALTED}.
  - Constant array BR_LUT: [0]=+3, [1]=-2, [2]=+16, all other entries +1.
- Sub-module branch_lut: combinational, BR_IDX → signed OFF_W offset read from BR_LUT; instantiated once.
- PC, counter and FSM live in fetch_sequencer.

Test Plan:
- Reset, then START=1 with START_ADDR=0x010, then 3 plain cycles → PC=0x010 after the start edge, then 0x013; INST_CNT=3; INST_VALID=1; DONE=0.
- At PC=0x013: BRANCH=1, BR_IDX=0 → PC=0x016. Next cycle BRANCH=1, BR_IDX=1 → PC=0x014. INST_CNT advances by 2.
- STALL=1 for 2 cycles with BRANCH=1 and HALT=1 asserted at PC=0x014 → PC stays 0x014, INST_CNT unchanged, state RUN.
- HALT=1 and BRANCH=1 in the same cycle at PC=0x020 → PC stays 0x020; DONE=1 and INST_VALID=0 after the edge; a later START_ADDR=0x005 with START=1 → PC=0x005, DONE=0, INST_CNT=0.
- Wrap: START_ADDR=0x3FF, one plain cycle → PC=0x000; then BRANCH with BR_IDX=1 → PC=0x3FE.
- Reset asserted mid-RUN at PC=0x123 with BRANCH=1 → PC=0, state IDLE, INST_CNT=0. START asserted during RUN is ignored (PC follows the sequential/branch rules, no reload).

Source files
------------

// File: rtl/definitions.sv
// rtl/definitions.sv - shared types, defaults and branch-offset table for fetch_sequencer
//
// Purpose: package imported by every fetch_sequencer file.
//   fetch_state : sequencer FSM states (IDLE, RUN, HALTED)
//   BR_LUT      : constant signed branch-offset table, one entry per branch index
// No ports (package).
package definitions;

  localparam int PC_W_DEF  = 10;
  localparam int OFF_W_DEF = 8;
  localparam int IDX_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  localparam int LUT_DEPTH = 1 << IDX_W_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state;

  typedef logic [LUT_DEPTH-1:0][OFF_W_DEF-1:0] br_lut_t;

  // Entries 0..2 carry the interesting offsets; every other index is a +1 skip.
  function automatic br_lut_t build_br_lut();
    br_lut_t t;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      t[i] = 8'h01;
    end
    t[0] = 8'h03;  // +3
    t[1] = 8'hFE;  // -2
    t[2] = 8'h10;  // +16
    return t;
  endfunction

  localparam br_lut_t BR_LUT = build_br_lut();

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - control/status bundle between fetch_sequencer and its driver
//
// Purpose: groups the sequencer's control inputs and status outputs.
//   START/START_ADDR     : begin execution at START_ADDR
//   BRANCH/BR_IDX/HALT   : decoded per-instruction control
//   STALL                : freeze sequencing this cycle
//   PC/INST_VALID/DONE/INST_CNT : sequencer status
// Modports: master drives control (testbench/top level), slave is the sequencer.
interface fetch_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
);

  logic             START;
  logic [PC_W-1:0]  START_ADDR;
  logic             BRANCH;
  logic [IDX_W-1:0] BR_IDX;
  logic             HALT;
  logic             STALL;
  logic [PC_W-1:0]  PC;
  logic             INST_VALID;
  logic             DONE;
  logic [CNT_W-1:0] INST_CNT;

  modport master (
    output START, START_ADDR, BRANCH, BR_IDX, HALT, STALL,
    input  PC, INST_VALID, DONE, INST_CNT
  );

  modport slave (
    input  START, START_ADDR, BRANCH, BR_IDX, HALT, STALL,
    output PC, INST_VALID, DONE, INST_CNT
  );

endinterface

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - combinational branch-index to signed offset lookup
//
// Purpose: reads the constant BR_LUT table and sign-extends the entry to OFF_W.
//   br_idx : branch-offset table index from the instruction field
//   offset : signed PC-relative branch offset
module branch_lut
  import definitions::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int OFF_W = OFF_W_DEF
) (
  input  logic [IDX_W-1:0]        br_idx,
  output logic signed [OFF_W-1:0] offset
);

  logic signed [OFF_W_DEF-1:0] entry;

  assign entry  = BR_LUT[br_idx];
  // Signed size cast so a wider OFF_W still sign-extends the table entry.
  assign offset = OFF_W'(entry);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, instruction counter and run/halt sequencing
//
// Purpose: owns the PC and sequences IDLE -> RUN -> HALTED with PC-relative branches.
//   CLK   : system clock, rising edge
//   Reset : synchronous, active-high
//   bus   : fetch_sequencer_if slave (START/START_ADDR/BRANCH/BR_IDX/HALT/STALL in,
//           PC/INST_VALID/DONE/INST_CNT out)
module fetch_sequencer
  import definitions::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic              CLK,
  input logic              Reset,
  fetch_sequencer_if.slave bus
);

  fetch_state              state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic signed [OFF_W-1:0] br_off;
  logic [CNT_W-1:0]        cnt_inc;
  logic [PC_W-1:0]         br_target;

  branch_lut #(
    .IDX_W(IDX_W),
    .OFF_W(OFF_W)
  ) u_branch_lut (
    .br_idx(bus.BR_IDX),
    .offset(br_off)
  );

  // Counter sticks at all-ones instead of wrapping.
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  // Signed cast sign-extends the offset; the add then wraps modulo 2^PC_W.
  assign br_target = pc_q + PC_W'(br_off);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      IDLE, HALTED: begin
        if (bus.START) begin
          state_d = RUN;
          pc_d    = bus.START_ADDR;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (bus.STALL) begin
          // full freeze; HALT/BRANCH this cycle are dropped
        end else if (bus.HALT) begin
          state_d = HALTED;
          done_d  = 1'b1;
          cnt_d   = cnt_inc;
        end else if (bus.BRANCH) begin
          pc_d    = br_target;
          cnt_d   = cnt_inc;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          cnt_d   = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.INST_VALID = (state_q == RUN);
  assign bus.DONE       = done_q;
  assign bus.INST_CNT   = cnt_q;

endmodule
